// File: rtl/vga_timing_gen.sv
// VGA timing generator: counts the raster, requests pixels from a fixed-latency source
// and re-aligns sync/blanking with the returned pixels. vga_* lags pix_req by PIX_LAT clocks.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int PIX_LAT   = 2,
  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
  localparam int XW       = $clog2(H_TOTAL),
  localparam int YW       = $clog2(V_TOTAL)
) (
  input  logic          vga_clk,
  input  logic          vga_rst_n,
  input  logic          enable,
  output logic          pix_req,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  input  logic          pix_valid,
  input  logic [11:0]   pix_rgb,
  output logic          frame_start,
  output logic          underflow,
  input  logic          underflow_clr,
  output logic          busy,
  output logic          vga_hSync,
  output logic          vga_vSync,
  output logic          vga_colorEn,
  output logic [3:0]    vga_color_r,
  output logic [3:0]    vga_color_g,
  output logic [3:0]    vga_color_b
);

  localparam logic [XW-1:0] H_ACT_END  = XW'(H_DISPLAY);
  localparam logic [XW-1:0] H_SYNC_BEG = XW'(H_DISPLAY + H_FRONT);
  localparam logic [XW-1:0] H_SYNC_END = XW'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT_END  = YW'(V_DISPLAY);
  localparam logic [YW-1:0] V_SYNC_BEG = YW'(V_DISPLAY + V_FRONT);
  localparam logic [YW-1:0] V_SYNC_END = YW'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state;
  logic [XW-1:0]   h;
  logic [YW-1:0]   v;
  logic            frame_end;
  logic            active;
  logic            hs_win;
  logic            vs_win;
  logic            hs0;
  logic            vs0;
  logic [PIX_LAT-1:0] ce_pipe;
  logic [PIX_LAT-1:0] hs_pipe;
  logic [PIX_LAT-1:0] vs_pipe;
  logic            ce_due;

  assign busy      = (state != IDLE);
  assign frame_end = (h == H_LAST) && (v == V_LAST);
  assign active    = busy && (h < H_ACT_END) && (v < V_ACT_END);
  assign hs_win    = busy && (h >= H_SYNC_BEG) && (h < H_SYNC_END);
  assign vs_win    = busy && (v >= V_SYNC_BEG) && (v < V_SYNC_END);

  // Frames are never cut short: leaving RUN only takes effect on the last clock of a frame.
  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      state <= IDLE;
      h     <= '0;
      v     <= '0;
    end else begin
      case (state)
        IDLE: begin
          h <= '0;
          v <= '0;
          if (enable) state <= RUN;
        end
        RUN, DRAIN: begin
          if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
          end else begin
            h <= h + 1'b1;
          end
          if (frame_end)
            state <= enable ? RUN : IDLE;
          else if (state == RUN && !enable)
            state <= DRAIN;
          else if (state == DRAIN && enable)
            state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      hs0         <= 1'b0;
      vs0         <= 1'b0;
    end else begin
      pix_req     <= active;
      pix_x       <= active ? h : '0;
      pix_y       <= active ? v : '0;
      frame_start <= busy && (h == '0) && (v == '0);
      hs0         <= hs_win;
      vs0         <= vs_win;
    end
  end

  // Timing bits ride a shift register so they line up with the pixel returning from the source.
  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      ce_pipe <= '0;
      hs_pipe <= '0;
      vs_pipe <= '0;
    end else begin
      ce_pipe[0] <= pix_req;
      hs_pipe[0] <= hs0;
      vs_pipe[0] <= vs0;
      for (int i = 1; i < PIX_LAT; i++) begin
        ce_pipe[i] <= ce_pipe[i-1];
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
      end
    end
  end

  generate
    if (PIX_LAT == 1) begin : g_due_direct
      assign ce_due = pix_req;
    end else begin : g_due_piped
      assign ce_due = ce_pipe[PIX_LAT-2];
    end
  endgenerate

  assign vga_colorEn = ce_pipe[PIX_LAT-1];
  assign vga_hSync   = hs_pipe[PIX_LAT-1] ? SYNC_POL : ~SYNC_POL;
  assign vga_vSync   = vs_pipe[PIX_LAT-1] ? SYNC_POL : ~SYNC_POL;

  // A missing pixel is shown black and latched; a new miss wins over a clear.
  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      vga_color_r <= '0;
      vga_color_g <= '0;
      vga_color_b <= '0;
      underflow   <= 1'b0;
    end else begin
      if (ce_due && pix_valid) begin
        vga_color_r <= pix_rgb[11:8];
        vga_color_g <= pix_rgb[7:4];
        vga_color_b <= pix_rgb[3:0];
      end else begin
        vga_color_r <= '0;
        vga_color_g <= '0;
        vga_color_b <= '0;
      end
      if (ce_due && !pix_valid)
        underflow <= 1'b1;
      else if (underflow_clr)
        underflow <= 1'b0;
    end
  end

endmodule
